// File: rtl/axibram_cmd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axibram_cmd_seq                                            |
// | Description : Buffers BRAM write-port traffic and replays a block of     |
// |               stored words as a valid/ready command stream on start.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axibram_cmd_seq #(
  parameter int ADDRESS_BITS = 10,
  parameter int OUT_DEPTH    = 2
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic [ADDRESS_BITS-1:0] bram_waddr,
  input  logic                    bram_wen,
  input  logic [3:0]              bram_wstb,
  input  logic [31:0]             bram_wdata,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] start_addr,
  input  logic [ADDRESS_BITS-1:0] start_len,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [31:0]             cmd_data,
  output logic                    cmd_last
);

  localparam int         c_mem_depth = 1 << ADDRESS_BITS;
  localparam logic [1:0] c_out_depth = 2'(OUT_DEPTH);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              w_next_state;

  logic [31:0]             r_mem [c_mem_depth];
  logic [31:0]             r_rd_data;
  logic [ADDRESS_BITS-1:0] r_rd_addr;
  logic [ADDRESS_BITS-1:0] r_remaining;
  logic                    r_rd_vld;
  logic                    r_rd_last;

  // Two-entry output buffer: r_out_* is the stream head, r_sk_* sits behind it
  logic                    r_out_valid;
  logic [31:0]             r_out_data;
  logic                    r_out_last;
  logic                    r_sk_valid;
  logic [31:0]             r_sk_data;
  logic                    r_sk_last;
  logic                    r_done;

  logic                    w_pop;
  logic [1:0]              w_occ;
  logic                    w_issue;
  logic                    w_done_evt;
  logic                    w_busy;
  logic                    w_a_valid;
  logic [31:0]             w_a_data;
  logic                    w_a_last;
  logic                    w_b_valid;
  logic [31:0]             w_b_data;
  logic                    w_b_last;

  assign w_pop = r_out_valid & cmd_ready;
  // Occupancy after this cycle's pop, counting the read that lands this cycle
  assign w_occ = {1'b0, r_out_valid} + {1'b0, r_sk_valid} + {1'b0, r_rd_vld} - {1'b0, w_pop};

  // State register
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (start && !abort) w_next_state = c_st_run;
      c_st_run:   if (abort) w_next_state = c_st_idle;
                  else if (w_issue && (r_remaining == '0)) w_next_state = c_st_drain;
      c_st_drain: if (abort || w_done_evt) w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  // Output / control logic
  always_comb begin
    w_busy     = (r_state != c_st_idle);
    w_issue    = (r_state == c_st_run) && (w_occ < c_out_depth) && !abort;
    w_done_evt = (r_state == c_st_drain) && w_pop && r_out_last && !abort;
  end

  // Pop the head, then append the landing read word to the first free slot
  always_comb begin
    w_a_valid = r_out_valid;
    w_a_data  = r_out_data;
    w_a_last  = r_out_last;
    w_b_valid = r_sk_valid;
    w_b_data  = r_sk_data;
    w_b_last  = r_sk_last;
    if (w_pop) begin
      w_a_valid = r_sk_valid;
      w_a_data  = r_sk_data;
      w_a_last  = r_sk_last;
      w_b_valid = 1'b0;
    end
    if (r_rd_vld) begin
      if (!w_a_valid) begin
        w_a_valid = 1'b1;
        w_a_data  = r_rd_data;
        w_a_last  = r_rd_last;
      end else begin
        w_b_valid = 1'b1;
        w_b_data  = r_rd_data;
        w_b_last  = r_rd_last;
      end
    end
  end

  // Word buffer: byte-masked write, read-first synchronous read
  always_ff @(posedge aclk) begin
    for (int b = 0; b < 4; b++) begin
      if (bram_wen && bram_wstb[b]) begin
        r_mem[bram_waddr][8*b +: 8] <= bram_wdata[8*b +: 8];
      end
    end
    if (w_issue) begin
      r_rd_data <= r_mem[r_rd_addr];
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_data   <= '0;
      r_sk_last   <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_last   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if ((r_state == c_st_idle) && start) begin
        r_rd_addr   <= start_addr;
        r_remaining <= start_len;
      end else if (w_issue) begin
        r_rd_addr   <= r_rd_addr + ADDRESS_BITS'(1);
        r_remaining <= r_remaining - ADDRESS_BITS'(1);
      end
      r_rd_vld    <= w_issue;
      r_rd_last   <= w_issue && (r_remaining == '0);
      r_out_valid <= w_a_valid;
      r_out_data  <= w_a_data;
      r_out_last  <= w_a_last;
      r_sk_valid  <= w_b_valid;
      r_sk_data   <= w_b_data;
      r_sk_last   <= w_b_last;
      r_done      <= w_done_evt;
    end
  end

  assign busy      = w_busy;
  assign done      = r_done;
  assign cmd_valid = r_out_valid;
  assign cmd_data  = r_out_data;
  assign cmd_last  = r_out_last;

endmodule
`default_nettype wire

// File: doc/axibram_cmd_seq.md
Name: axibram_cmd_seq

Overview:
Downstream consumer of the AXI-to-BRAM write stage. It captures that stage's BRAM write port into an internal 2^ADDRESS_BITS x 32 buffer with byte strobes. On a start request it plays a block of stored words out, in order, as a valid/ready command stream. The stream feeds a command decoder (for example, memory-controller sequences), so software can preload a sequence over AXI and launch it with one strobe.

Parameters:
ADDRESS_BITS, 10, buffer address width; depth = 2^ADDRESS_BITS 32-bit words
OUT_DEPTH, 2, output skid buffer entries (fixed at 2; other values not supported)

Ports:
aclk  in  1  clock; the write-port clock is also aclk, and no separate write clock exists
rst  in  1  asynchronous, active-high reset
bram_waddr  in  ADDRESS_BITS  word address of the write
bram_wen  in  1  write enable, one word per cycle
bram_wstb  in  4  byte enables; bit i covers bits 8i+7:8i
bram_wdata  in  32  write data
start  in  1  one-cycle launch strobe
start_addr  in  ADDRESS_BITS  first word address, sampled with start
start_len  in  ADDRESS_BITS  word count minus 1, sampled with start
abort  in  1  stop the run and flush output
busy  out  1  run in progress (RUN or DRAIN)
done  out  1  one-cycle pulse after the last word is accepted
cmd_valid  out  1  stream valid
cmd_ready  in  1  stream ready
cmd_data  out  32  stream word
cmd_last  out  1  marks the final word of the run

Behaviour:
- Reset values: busy=0, done=0, cmd_valid=0, cmd_data=0, cmd_last=0; state IDLE; skid buffer empty.
- Buffer contents are not reset.
- Writes:
  - Accepted every cycle in which bram_wen=1, in every state.
  - Only bytes with bram_wstb[i]=1 are updated; wstb=0 with wen=1 writes nothing.
- Read port is synchronous, 1-cycle latency, read-first.
  - A read and a write to the same address in the same cycle return the old data.
  - A write one or more cycles before the read returns the new data.
- States:
  - IDLE: start=1 latches rd_addr=start_addr and remaining=start_len, then goes to RUN.
  - RUN: issues reads; after the read for remaining==0 is issued, goes to DRAIN.
  - DRAIN: waits until the skid buffer is empty and all reads have landed; then returns to IDLE with done=1 for exactly one cycle.
- start while busy=1 is ignored, with no effect on the current run.
- Read issue rule: a read is issued in a RUN cycle only if (buffered entries + reads in flight) < 2, counting an entry popped in the same cycle as free.
- On each read issue: rd_addr increments modulo 2^ADDRESS_BITS (wraps from the top address to 0), and remaining decrements.
- Latency: with start sampled at edge N and cmd_ready held at 1, cmd_valid is 1 after edge N+2 carrying word start_addr.
- Throughput: sustained 1 word/cycle while cmd_ready=1.
- Stream rules:
  - cmd_valid, cmd_data and cmd_last are registered and hold stable while cmd_valid=1 and cmd_ready=0.
  - No bubbles are inserted once data is buffered and cmd_ready=1.
  - cmd_last=1 only on the word issued with remaining==0.
- Run length: start_len=0 gives 1 word; the all-ones value gives 2^ADDRESS_BITS words and reads every address exactly once.
- done is asserted in the cycle following the cmd_valid&cmd_ready handshake of the cmd_last word. busy falls in that same cycle.
- abort:
  - Takes effect at the next edge in any state: skid buffer and in-flight reads are discarded, state returns to IDLE, busy=0, cmd_valid=0.
  - done is not pulsed.
  - abort together with start in IDLE: abort wins, no run.
  - abort in IDLE has no effect.
- Async rst mid-run: returns all outputs to reset values immediately; buffer contents are preserved (best effort, not verified).

Test Plan:
- Write 0x11111111..0x44444444 to addresses 0..3, then start (addr 0, len 3) with cmd_ready=1 -> cmd_valid high from edge N+2 for 4 consecutive cycles with data 0x11111111,0x22222222,0x33333333,0x44444444; cmd_last on the 4th; done 1 cycle later; busy low together with done.
- Byte strobes: write 0xAABBCCDD to addr 5, then write 0x00000000 with wstb=4'b0101, then run 1 word -> cmd_data=0xAA00CC00.
- Backpressure: 8-word run with cmd_ready toggling 1,0,0,1 repeating -> all 8 words delivered in order, no loss or duplication; cmd_data stable while stalled; read never issued with 2 entries pending.
- Wrap-around (ADDRESS_BITS=10): start addr 1022, len 3 -> words from 1022, 1023, 0, 1; cmd_last on the 4th.
- Collisions: same-cycle write to the address being read returns old data; a write landing on a later address before its read returns new data. start during busy ignored, so exactly the original word count is emitted.
- abort after 2 handshakes of a 6-word run with cmd_ready=0 -> cmd_valid=0 next cycle, busy=0, no done pulse; a following start (len 0) delivers exactly 1 correct word.
